// File: rtl/opl3_arb_pkg.sv
// Shared types and encodings for the OPL3 host register bus arbiter.
package opl3_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_STB,
    ADDR_GAP,
    DATA_STB,
    DATA_GAP
  } state_t;

  typedef struct packed {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } opl3_wr_req_t;

  // A0 selects the index latch (0) or the data port (1) on the OPL3 bus.
  localparam logic A0_ADDR = 1'b0;
  localparam logic A0_DATA = 1'b1;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opl3_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module opl3_rr_arbiter
  import opl3_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/opl3_host_bus_arbiter.sv
// Round-robin sharing of the OPL3 write bus; each grant runs an address then data strobe.
// Define OPL3_ARB_ADDR_CACHE_EN to skip the address phase when {bank,addr} repeats.
module opl3_host_bus_arbiter
  import opl3_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int WR_PULSE  = 2,
  parameter int ADDR_WAIT = 4,
  parameter int DATA_WAIT = 8,
  localparam int IW       = idx_w(NUM_REQ)
) (
  input  logic                    clk_host,
  input  logic                    ic_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_bank,
  input  logic [NUM_REQ-1:0][7:0] req_addr,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  output logic                    cs_n,
  output logic                    wr_n,
  output logic                    rd_n,
  output logic [1:0]              address,
  output logic [7:0]              din,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);

  state_t        state, state_nx;
  logic [15:0]   cnt, cnt_nx;
  logic [IW-1:0] ptr, gid, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic          win_any, take, hit, load_data;
  opl3_wr_req_t  req_q, win_req;
  logic [1:0]    addr_q;
  logic [7:0]    din_q;

  opl3_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_req.bank = req_bank[win_idx];
    win_req.addr = req_addr[win_idx];
    win_req.data = req_data[win_idx];
  end

  // Gating with ic_n keeps req_ready low while held in reset.
  assign take      = ic_n && (state == IDLE) && win_any;
  assign req_ready = take ? win_gnt : '0;

`ifdef OPL3_ARB_ADDR_CACHE_EN
  logic [8:0] cache_q;
  logic       cache_vld;

  assign hit = cache_vld && (cache_q == {win_req.bank, win_req.addr});

  always_ff @(posedge clk_host or negedge ic_n) begin
    if (!ic_n) begin
      cache_q   <= '0;
      cache_vld <= 1'b0;
    end else if (state == ADDR_STB && state_nx != ADDR_STB) begin
      cache_q   <= {req_q.bank, req_q.addr};
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 16'd1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (take) state_nx = hit ? DATA_STB : ADDR_STB;
      end
      ADDR_STB: if (cnt == 16'(WR_PULSE - 1)) begin
        cnt_nx   = '0;
        state_nx = (ADDR_WAIT > 0) ? ADDR_GAP : DATA_STB;
      end
      ADDR_GAP: if (cnt == 16'(ADDR_WAIT - 1)) begin
        cnt_nx   = '0;
        state_nx = DATA_STB;
      end
      DATA_STB: if (cnt == 16'(WR_PULSE - 1)) begin
        cnt_nx   = '0;
        state_nx = (DATA_WAIT > 0) ? DATA_GAP : IDLE;
      end
      DATA_GAP: if (cnt == 16'(DATA_WAIT - 1)) begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign load_data = (state_nx == DATA_STB) && (state != DATA_STB);

  always_ff @(posedge clk_host or negedge ic_n) begin
    if (!ic_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      gid    <= '0;
      req_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take) begin
        req_q  <= win_req;
        gid    <= win_idx;
        ptr    <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        addr_q <= {win_req.bank, A0_ADDR};
        din_q  <= win_req.addr;
      end
      // On a cache hit the data phase starts straight from the grant cycle.
      if (load_data) begin
        addr_q <= {(take ? win_req.bank : req_q.bank), A0_DATA};
        din_q  <= take ? win_req.data : req_q.data;
      end
    end
  end

  assign cs_n     = !((state == ADDR_STB) || (state == DATA_STB));
  assign wr_n     = cs_n;
  assign rd_n     = 1'b1;
  assign address  = addr_q;
  assign din      = din_q;
  assign busy     = (state != IDLE);
  assign grant_id = gid;

endmodule

// File: tb/tb_opl3_host_bus_arbiter.sv
// Bench: timeline model checks DUT A every cycle; directed literals pin the model and DUT B.
module tb_opl3_host_bus_arbiter;

  localparam int N = 2, P = 2, AW = 4, DW = 8;
`ifdef OPL3_ARB_ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic ic_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      a_rv = '0, a_rb = '0, a_ready;
  logic [1:0][7:0] a_ra = '0, a_rdat = '0;
  logic a_cs_n, a_wr_n, a_rd_n, a_busy, a_gid;
  logic [1:0] a_address;
  logic [7:0] a_din;

  logic [1:0]      b_rv = '0, b_rb = '0, b_ready;
  logic [1:0][7:0] b_ra = '0, b_rdat = '0;
  logic b_cs_n, b_wr_n, b_rd_n, b_busy, b_gid;
  logic [1:0] b_address;
  logic [7:0] b_din;

  opl3_host_bus_arbiter dut_a (
    .clk_host(clk), .ic_n(ic_n), .req_valid(a_rv), .req_ready(a_ready), .req_bank(a_rb),
    .req_addr(a_ra), .req_data(a_rdat), .cs_n(a_cs_n), .wr_n(a_wr_n), .rd_n(a_rd_n),
    .address(a_address), .din(a_din), .busy(a_busy), .grant_id(a_gid));

  opl3_host_bus_arbiter #(.NUM_REQ(2), .WR_PULSE(1), .ADDR_WAIT(0), .DATA_WAIT(0)) dut_b (
    .clk_host(clk), .ic_n(ic_n), .req_valid(b_rv), .req_ready(b_ready), .req_bank(b_rb),
    .req_addr(b_ra), .req_data(b_rdat), .cs_n(b_cs_n), .wr_n(b_wr_n), .rd_n(b_rd_n),
    .address(b_address), .din(b_din), .busy(b_busy), .grant_id(b_gid));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each write is a timeline measured in cycles since its accept.
  int m_t, m_len, m_ds, m_ptr, m_gid;
  bit m_act, m_hit, c_vld;
  logic [8:0] c_val;
  logic m_bank;
  logic [7:0] m_addr, m_data;

  always @(negedge clk) begin : cmp
    bit idle, e_stb;
    logic [1:0] e_addr, e_rdy;
    logic [7:0] e_din;
    int w;
    if (!ic_n) begin
      m_act = 0; m_t = 0; m_ptr = 0; m_gid = 0; c_vld = 0; c_val = '0; m_hit = 0;
      m_len = 0; m_ds = 0; m_bank = 0; m_addr = '0; m_data = '0;
    end
    idle  = !m_act || (m_t > m_len);
    e_stb = !idle && ((!m_hit && m_t <= P) || (m_t >= m_ds && m_t < m_ds + P));
    if (!m_act) begin
      e_addr = 2'b00; e_din = 8'h00;
    end else if (m_t < m_ds) begin
      e_addr = {m_bank, 1'b0}; e_din = m_addr;
    end else begin
      e_addr = {m_bank, 1'b1}; e_din = m_data;
    end
    e_rdy = 2'b00;
    w = -1;
    if (ic_n && idle)
      for (int i = 0; i < N; i++)
        if (w < 0 && a_rv[(m_ptr + i) % N]) w = (m_ptr + i) % N;
    if (w >= 0) e_rdy[w] = 1'b1;
    chk("cs_n", a_cs_n, !e_stb);
    chk("wr_n", a_wr_n, !e_stb);
    chk("rd_n", a_rd_n, 1);
    chk("busy", a_busy, !idle);
    chk("address", a_address, e_addr);
    chk("din", a_din, e_din);
    chk("grant_id", a_gid, m_gid);
    chk("req_ready", a_ready, e_rdy);
    if (w >= 0) begin
      m_hit = CACHE_EN && c_vld && (c_val == {a_rb[w], a_ra[w]});
      if (!m_hit) begin c_val = {a_rb[w], a_ra[w]}; c_vld = 1; end
      m_act = 1; m_t = 1; m_gid = w; m_ptr = (w + 1) % N;
      m_bank = a_rb[w]; m_addr = a_ra[w]; m_data = a_rdat[w];
      m_ds  = m_hit ? 1 : P + AW + 1;
      m_len = m_hit ? P + DW : 2 * P + AW + DW;
    end else if (m_act && m_t <= m_len) begin
      m_t++;
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic do_reset();
    ic_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    ic_n = 1'b1;
  endtask

  task automatic wait_rdy_a(input int r, output bit seen);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_ready[r]) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("handshake", seen, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = !a_busy;
      @(posedge clk); #1;
    end
    chk("idle_timeout", done, 1);
  endtask

  task automatic do_write(input int r, input logic b, input logic [7:0] ad, input logic [7:0] dt,
                          output int blen, output logic [1:0] af, output logic [7:0] df,
                          output logic [1:0] al, output logic [7:0] dl);
    bit seen, first;
    blen = 0; af = '0; df = '0; al = '0; dl = '0; first = 1;
    a_rb[r] = b; a_ra[r] = ad; a_rdat[r] = dt; a_rv[r] = 1'b1;
    wait_rdy_a(r, seen);
    @(posedge clk); #1;
    a_rv[r] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!a_busy) break;
      blen++;
      if (!a_cs_n) begin
        if (first) begin af = a_address; df = a_din; first = 0; end
        al = a_address; dl = a_din;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen, prev, rdbad;
    int blen, n;
    logic [1:0] af, al, ba1, ba2;
    logic [7:0] df, dl, bd1, bd2;
    logic [31:0] rm, sm, bm;
    logic [3:0] order;

    #2 ic_n = 1'b0;
    #1;
    chk("rst_cs_n", a_cs_n, 1);
    chk("rst_wr_n", a_wr_n, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_address", a_address, 0);
    chk("rst_din", a_din, 0);
    chk("rst_gid", a_gid, 0);
    chk("rst_b_cs_n", b_cs_n, 1);
    repeat (2) @(posedge clk);
    #1 ic_n = 1'b1;

    // Single write with valid held: strobe/busy/ready masks vs accept cycle.
    a_rb[0] = 0; a_ra[0] = 8'hB0; a_rdat[0] = 8'h31; a_rv[0] = 1;
    wait_rdy_a(0, seen);
    rm = 32'h1; sm = '0; bm = '0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (a_ready[0]) rm[k] = 1'b1;
      if (!a_cs_n && !a_wr_n) sm[k] = 1'b1;
      if (a_busy) bm[k] = 1'b1;
      if (k == 1) begin af = a_address; df = a_din; end
      if (k == 7) begin al = a_address; dl = a_din; end
    end
    @(posedge clk); #1;
    a_rv[0] = 0;
    chk("t1_ready_mask", rm, 32'h0002_0001);
    chk("t1_strobe_mask", sm, 32'h0000_0186);
    chk("t1_busy_mask", bm, 32'h0001_FFFE);
    chk("t1_addr_phase", {af, df}, {2'b00, 8'hB0});
    chk("t1_data_phase", {al, dl}, {2'b01, 8'h31});
    wait_idle();

    // Two requesters held together from pointer 0.
    do_reset();
    a_ra[0] = 8'h60; a_rdat[0] = 8'h01; a_ra[1] = 8'h61; a_rdat[1] = 8'h02; a_rb = 2'b00;
    a_rv = 2'b11;
    n = 0; order = '0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if (a_ready != 2'b00) begin order[n] = a_ready[1]; n++; end
      @(posedge clk); #1;
    end
    a_rv = 2'b00;
    chk("t2_grants", n, 4);
    chk("t2_order", order, 4'b1010);
    wait_idle();

    // Bank 1 write.
    do_write(1, 1'b1, 8'h05, 8'h01, blen, af, df, al, dl);
    chk("t3_busy_len", blen, 16);
    chk("t3_addr_phase", {af, df}, {2'b10, 8'h05});
    chk("t3_data_phase", {al, dl}, {2'b11, 8'h01});

    // Reset during the data strobe; a waiting request gets a full fresh sequence.
    a_rb[0] = 0; a_ra[0] = 8'h40; a_rdat[0] = 8'h55; a_rv[0] = 1;
    wait_rdy_a(0, seen);
    @(posedge clk); #1;
    a_rv[0] = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) begin a_ra[0] = 8'h41; a_rdat[0] = 8'h66; a_rv[0] = 1; end
      @(negedge clk);
      if (k < 7) begin @(posedge clk); #1; end
    end
    chk("t4_in_data_stb", {a_cs_n, a_address, a_din}, {1'b0, 2'b01, 8'h55});
    #2 ic_n = 1'b0;
    #1;
    chk("t4_async_abort", {a_cs_n, a_wr_n, a_busy}, 3'b110);
    @(negedge clk);
    @(posedge clk); #1;
    ic_n = 1'b1;
    @(negedge clk);
    chk("t4_regrant", a_ready, 2'b01);
    @(posedge clk); #1;
    a_rv[0] = 0;
    @(negedge clk);
    chk("t4_fresh_addr_phase", {a_cs_n, a_address, a_din}, {1'b0, 2'b00, 8'h41});
    @(posedge clk); #1;
    wait_idle();

    // Repeated register: address phase skipped only with the cache.
    do_write(0, 1'b0, 8'h20, 8'h11, blen, af, df, al, dl);
    chk("t5_first_len", blen, 16);
    do_write(0, 1'b0, 8'h20, 8'h22, blen, af, df, al, dl);
    chk("t5_repeat_len", blen, CACHE_EN ? 10 : 16);
    chk("t5_repeat_first_stb", {af, df}, CACHE_EN ? {2'b01, 8'h22} : {2'b00, 8'h20});
    do_write(0, 1'b0, 8'h21, 8'h33, blen, af, df, al, dl);
    chk("t5_new_len", blen, 16);
    chk("t5_new_data", {al, dl}, {2'b01, 8'h33});

    // Minimum timing on DUT B; address changes every grant so no cache hits.
    b_rb[0] = 0; b_ra[0] = 8'h10; b_rdat[0] = 8'h77; b_rv[0] = 1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_ready[0]) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("t6_handshake", seen, 1);
    rm = 32'h1; sm = '0; bm = '0; prev = 1; rdbad = 0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (prev) b_ra[0] = b_ra[0] + 8'h1;
      @(negedge clk);
      prev = b_ready[0];
      if (prev) rm[k] = 1'b1;
      if (!b_cs_n && !b_wr_n) sm[k] = 1'b1;
      if (b_busy) bm[k] = 1'b1;
      if (b_rd_n !== 1'b1) rdbad = 1;
      if (k == 1) begin ba1 = b_address; bd1 = b_din; end
      if (k == 2) begin ba2 = b_address; bd2 = b_din; end
    end
    @(posedge clk); #1;
    b_rv[0] = 0;
    chk("t6_ready_mask", rm, 32'h249);
    chk("t6_strobe_mask", sm, 32'h1B6);
    chk("t6_busy_mask", bm, 32'h1B6);
    chk("t6_addr_phase", {ba1, bd1}, {2'b00, 8'h10});
    chk("t6_data_phase", {ba2, bd2}, {2'b01, 8'h77});
    chk("t6_rd_n", rdbad, 0);
    chk("t6_gid", b_gid, 0);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
